pipelined_cla_adder_16: RTL and testbench

PIPELINED_CLA_ADDER_16 -- requirements
Module: pipelined_cla_adder_16

---
 rtl/pipelined_cla_adder_16.sv | 124 ++++++++++++
 tb/tb_pipelined_cla_adder_16.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_16.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready handshake.
// Stage 1 registers bit and group propagate/generate; stage 2 resolves carries and the sum.
module pipelined_cla_adder_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        grp_p,
  output logic        grp_g
);

  // Carries into positions 0..3 of a 4-wide lookahead block, fully flattened.
  function automatic logic [3:0] lookahead(input logic [3:0] p, input logic [3:0] g,
                                           input logic c);
    logic [3:0] c_out;
    c_out[0] = c;
    c_out[1] = g[0] | (p[0] & c);
    c_out[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c_out[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    return c_out;
  endfunction

  // Block propagate in bit 1, block generate in bit 0.
  function automatic logic [1:0] block_pg(input logic [3:0] p, input logic [3:0] g);
    logic gen;
    gen = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {&p, gen};
  endfunction

  logic        s1_valid;
  logic [15:0] s1_p, s1_g;
  logic [3:0]  s1_gp, s1_gg;
  logic        s1_cin;

  logic        s2_free, accept, advance;
  logic [15:0] bit_p, bit_g;
  logic [3:0]  gp_d, gg_d;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid && s2_free;

  // NOTE: every signal written in an always_comb gets a value on every path; here the
  // loop covers all group slots, so no latch is inferred.
  always_comb begin
    bit_p = a ^ b;
    bit_g = a & b;
    gp_d  = '0;
    gg_d  = '0;
    for (int k = 0; k < 4; k++) begin
      {gp_d[k], gg_d[k]} = block_pg(bit_p[4*k +: 4], bit_g[4*k +: 4]);
    end
  end

  // NOTE: datapath registers are reset along with the valid bits so nothing downstream
  // can ever observe X, even before the first beat arrives.
  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
      s1_cin   <= 1'b0;
    end else begin
      s1_valid <= accept || (s1_valid && !advance);
      if (accept) begin
        s1_p   <= bit_p;
        s1_g   <= bit_g;
        s1_gp  <= gp_d;
        s1_gg  <= gg_d;
        s1_cin <= cin;
      end
    end
  end

  logic [3:0]  grp_carry;
  logic [15:0] carry;
  logic [1:0]  blk_pg;
  logic        c16;

  // Second-level lookahead over the four groups, then first-level inside each group.
  always_comb begin
    grp_carry = lookahead(s1_gp, s1_gg, s1_cin);
    blk_pg    = block_pg(s1_gp, s1_gg);
    c16       = blk_pg[0] | (blk_pg[1] & s1_cin);
    carry     = '0;
    for (int k = 0; k < 4; k++) begin
      carry[4*k +: 4] = lookahead(s1_p[4*k +: 4], s1_g[4*k +: 4], grp_carry[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      grp_p     <= 1'b0;
      grp_g     <= 1'b0;
    end else begin
      out_valid <= advance || (out_valid && !out_ready);
      if (advance) begin
        sum   <= s1_p ^ carry;
        cout  <= c16;
        ovf   <= carry[15] ^ c16;
        grp_p <= blk_pg[1];
        grp_g <= blk_pg[0];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder_16.sv
// Self-checking bench: directed corner vectors, streaming, stall and reset scenarios,
// then randomized traffic, all scored against an arithmetic reference model.
module tb_pipelined_cla_adder_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout, ovf, grp_p, grp_g;

  always #5 clk = ~clk;

  pipelined_cla_adder_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .grp_p     (grp_p),
    .grp_g     (grp_g)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        gp;
    logic        gg;
  } res_t;

  res_t dut_res;
  assign dut_res = {sum, cout, ovf, grp_p, grp_g};

  int   n_vec = 0;
  int   n_err = 0;
  res_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 17-bit arithmetic and sign rules.
  function automatic res_t ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    res_t        r;
    logic [16:0] t, u;
    t      = 17'(x) + 17'(y) + 17'(c);
    u      = 17'(x) + 17'(y);
    r.sum  = t[15:0];
    r.cout = t[16];
    r.ovf  = (x[15] == y[15]) && (t[15] != x[15]);
    r.gp   = ((x ^ y) == 16'hFFFF);
    r.gg   = u[16];
    return r;
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] corners [5];
    corners = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  // Scoreboard: sampled mid-cycle, it predicts the handshake outcome of the next edge.
  res_t held;
  bit   hold_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(dut_res), 32'(held));
      end
      check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
      if (out_valid && out_ready) begin
        check("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("result", 32'(dut_res), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(a, b, cin));
      hold_prev = out_valid && !out_ready;
      held      = dut_res;
    end
  end

  task automatic directed(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input res_t exp);
    int lat;
    @(posedge clk); #1;
    a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check(tag, 32'(dut_res), 32'(exp));
  endtask

  initial begin
    logic [11:0] ov_hist;
    logic [4:0]  ir_hist;
    int          acc;
    int          guard;

    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'(dut_res), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b1;

    directed("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    directed("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
    directed("neg_ovf",     16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b1});
    directed("full_ripple", 16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});

    // Eight back-to-back beats: results must appear on eight consecutive cycles.
    ov_hist = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      ov_hist[i] = out_valid;
      if (i < 8) check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    check("stream_out_pattern", 32'(ov_hist), 32'h3FC);

    // Stall with a stream offered: exactly two beats fit, inputs ignored afterwards.
    out_ready = 1'b0;
    ir_hist   = '0;
    acc       = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(negedge clk);
      ir_hist[i] = in_ready;
      if (in_valid && in_ready) acc++;
    end
    check("stall_in_ready_pattern", 32'(ir_hist), 32'h03);
    check("stall_accepted", 32'(acc), 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_drained", 32'(exp_q.size()), 32'd0);
    check("stall_out_idle", 32'(out_valid), 32'd0);

    // Reset with both stages full, then the first post-reset beat must come out alone.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs", 32'(dut_res), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    a = 16'h0003; b = 16'h0004; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 10);
    check("post_reset_valid", 32'(out_valid), 32'd1);
    check("post_reset_sum", 32'(sum), 32'h0007);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
